// File: rtl/bp_port_scheduler.sv
// Branch predictor port scheduler: arbitrates the single table port
// between IF prediction queries and buffered RoB updates.
module bp_port_scheduler #(
  parameter int UPD_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         if_query_valid,
  input  logic [31:0]                  if_query_pc,
  output logic                         if_query_ready,
  output logic                         if_resp_valid,
  output logic                         if_resp_taken,
  input  logic                         rob_upd_valid,
  input  logic [31:0]                  rob_upd_pc,
  input  logic                         rob_upd_taken,
  output logic                         rob_upd_ready,
  output logic [$clog2(UPD_DEPTH):0]   upd_count,
  output logic                         bp_query_en,
  output logic [31:0]                  bp_query_pc,
  output logic                         bp_update_en,
  output logic [31:0]                  bp_update_pc,
  output logic                         bp_update_res,
  input  logic                         bp_result_en,
  input  logic                         bp_result
);

  localparam int AW = $clog2(UPD_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    G_IDLE,
    G_QUERY,
    G_UPDATE
  } grant_e;

  logic [31:0]   pc_mem [UPD_DEPTH];
  logic          tk_mem [UPD_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic          q_pending;

  logic   active;
  logic   empty;
  logic   full;
  logic   force_upd;
  logic   push;
  logic   pop;
  grant_e grant;

  // Outputs stay low while reset is asserted, even before the first edge.
  assign active    = rst_in & rdy_in;
  assign empty     = (count == '0);
  assign full      = (count == CW'(UPD_DEPTH));
  assign force_upd = full | ((starve == SW'(STARVE_LIMIT)) & ~empty);

  always_comb begin
    grant = G_IDLE;
    if (active) begin
      if (force_upd)
        grant = G_UPDATE;
      else if (if_query_valid && !flush_in)
        grant = G_QUERY;
      else if (!empty)
        grant = G_UPDATE;
    end
  end

  assign rob_upd_ready  = active & ~full;
  assign push           = rob_upd_valid & rob_upd_ready;
  assign pop            = (grant == G_UPDATE);

  assign if_query_ready = active & ~force_upd & ~flush_in;
  assign bp_query_en    = (grant == G_QUERY);
  assign bp_query_pc    = bp_query_en ? if_query_pc : '0;

  assign bp_update_en   = pop;
  assign bp_update_pc   = pop ? pc_mem[head] : '0;
  assign bp_update_res  = pop & tk_mem[head];

  assign if_resp_valid  = active & q_pending & bp_result_en & ~flush_in;
  assign if_resp_taken  = if_resp_valid & bp_result;
  assign upd_count      = rst_in ? count : '0;

  always_ff @(posedge clk_in) begin
    if (push) begin
      pc_mem[tail] <= rob_upd_pc;
      tk_mem[tail] <= rob_upd_taken;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      starve    <= '0;
      q_pending <= 1'b0;
    end else if (rdy_in) begin
      if (push)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || empty)
        starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))
        starve <= starve + 1'b1;
      // A response slot lives exactly one active cycle; flush clears it
      // because a flushed cycle never grants a query.
      q_pending <= (grant == G_QUERY);
    end
  end

endmodule

// File: tb/tb_bp_port_scheduler.sv
// Bench for bp_port_scheduler: directed vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_bp_port_scheduler;

  localparam int D = 4;
  localparam int L = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        if_query_valid = 1'b0;
  logic [31:0] if_query_pc = '0;
  logic        if_query_ready;
  logic        if_resp_valid;
  logic        if_resp_taken;
  logic        rob_upd_valid = 1'b0;
  logic [31:0] rob_upd_pc = '0;
  logic        rob_upd_taken = 1'b0;
  logic        rob_upd_ready;
  logic [2:0]  upd_count;
  logic        bp_query_en;
  logic [31:0] bp_query_pc;
  logic        bp_update_en;
  logic [31:0] bp_update_pc;
  logic        bp_update_res;
  logic        bp_result_en = 1'b0;
  logic        bp_result = 1'b0;

  int nchk = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  bp_port_scheduler #(.UPD_DEPTH(D), .STARVE_LIMIT(L)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush_in(flush_in),
    .if_query_valid(if_query_valid), .if_query_pc(if_query_pc),
    .if_query_ready(if_query_ready),
    .if_resp_valid(if_resp_valid), .if_resp_taken(if_resp_taken),
    .rob_upd_valid(rob_upd_valid), .rob_upd_pc(rob_upd_pc),
    .rob_upd_taken(rob_upd_taken), .rob_upd_ready(rob_upd_ready),
    .upd_count(upd_count),
    .bp_query_en(bp_query_en), .bp_query_pc(bp_query_pc),
    .bp_update_en(bp_update_en), .bp_update_pc(bp_update_pc),
    .bp_update_res(bp_update_res),
    .bp_result_en(bp_result_en), .bp_result(bp_result)
  );

  typedef struct {
    bit          rst, rdy, flush, qv;
    logic [31:0] qpc;
    bit          uv;
    logic [31:0] upc;
    bit          ut, ren, res;
  } in_t;

  typedef struct {
    in_t         i;
    bit          qrdy, rv, rt, urdy;
    int          cnt;
    bit          qen;
    logic [31:0] qpc;
    bit          uen;
    logic [31:0] upc;
    bit          ures;
  } vec_t;

  // Reference model: FIFO of {taken, pc}, starvation age, pending response
  logic [32:0] mq[$];
  int          mstarve = 0;
  bit          mpend = 0;

  function automatic in_t mi(bit rst, bit rdy, bit flush, bit qv,
                             logic [31:0] qpc, bit uv, logic [31:0] upc,
                             bit ut, bit ren, bit res);
    in_t r;
    r.rst = rst; r.rdy = rdy; r.flush = flush; r.qv = qv; r.qpc = qpc;
    r.uv = uv; r.upc = upc; r.ut = ut; r.ren = ren; r.res = res;
    return r;
  endfunction

  function automatic in_t idle();
    return mi(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mv(in_t i, bit qrdy, bit rv, bit rt, bit urdy,
                              int cnt, bit qen, logic [31:0] qpc, bit uen,
                              logic [31:0] upc, bit ures);
    vec_t r;
    r.i = i; r.qrdy = qrdy; r.rv = rv; r.rt = rt; r.urdy = urdy;
    r.cnt = cnt; r.qen = qen; r.qpc = qpc; r.uen = uen; r.upc = upc;
    r.ures = ures;
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_step(in_t v);
    bit          act, frc, qg, ug, push, erv;
    int          sz;
    logic [32:0] hd;
    act  = v.rst && v.rdy;
    sz   = mq.size();
    frc  = (sz == D) || (mstarve == L && sz != 0);
    qg   = act && !frc && v.qv && !v.flush;
    ug   = act && sz != 0 && !qg;
    push = act && v.uv && sz < D;
    erv  = act && mpend && v.ren && !v.flush;
    hd   = (sz != 0) ? mq[0] : '0;
    chk("m_qrdy", 32'(if_query_ready), 32'(act && !frc && !v.flush));
    chk("m_urdy", 32'(rob_upd_ready), 32'(act && sz < D));
    chk("m_cnt", 32'(upd_count), v.rst ? 32'(sz) : 0);
    chk("m_qen", 32'(bp_query_en), 32'(qg));
    chk("m_qpc", bp_query_pc, qg ? v.qpc : 0);
    chk("m_uen", 32'(bp_update_en), 32'(ug));
    chk("m_upc", bp_update_pc, ug ? hd[31:0] : 0);
    chk("m_ures", 32'(bp_update_res), 32'(ug && hd[32]));
    chk("m_rv", 32'(if_resp_valid), 32'(erv));
    chk("m_rt", 32'(if_resp_taken), 32'(erv && v.res));
    if (!v.rst) begin
      mq.delete();
      mstarve = 0;
      mpend = 0;
    end else if (v.rdy) begin
      mstarve = (ug || sz == 0) ? 0 : ((mstarve < L) ? mstarve + 1 : L);
      if (ug) void'(mq.pop_front());
      if (push) mq.push_back({v.ut, v.upc});
      mpend = qg;
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check before rising edge
  task automatic cyc(in_t v);
    @(negedge clk_in);
    rst_in = v.rst; rdy_in = v.rdy; flush_in = v.flush;
    if_query_valid = v.qv; if_query_pc = v.qpc;
    rob_upd_valid = v.uv; rob_upd_pc = v.upc; rob_upd_taken = v.ut;
    bp_result_en = v.ren; bp_result = v.res;
    #1;
    model_step(v);
  endtask

  vec_t tbl[$];
  in_t  v;
  int   nq;
  bit   seen;

  initial begin
    // Reset with pushes held, single query, fill to full and drain in order
    tbl.push_back(mv(mi(0,1,0,0,0,1,1,0,0,0), 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mv(mi(0,1,0,0,0,1,1,0,0,0), 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mv(mi(1,1,0,0,0,0,0,0,0,0), 1,0,0,1,0,0,0,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h10,0,0,0,0,0), 1,0,0,1,0,1,'h10,0,0,0));
    tbl.push_back(mv(mi(1,1,0,0,0,0,0,0,1,1), 1,1,1,1,0,0,0,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h20,1,'h100,1,0,0), 1,0,0,1,0,1,'h20,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h24,1,'h104,0,0,0), 1,0,0,1,1,1,'h24,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h28,1,'h108,1,0,0), 1,0,0,1,2,1,'h28,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h2c,1,'h10c,0,0,0), 1,0,0,1,3,1,'h2c,0,0,0));
    tbl.push_back(mv(mi(1,1,0,1,'h30,1,'h110,1,0,0), 0,0,0,0,4,0,0,1,'h100,1));
    tbl.push_back(mv(mi(1,1,0,1,'h34,0,0,0,0,0), 1,0,0,1,3,1,'h34,0,0,0));
    tbl.push_back(mv(idle(), 1,0,0,1,3,0,0,1,'h104,0));
    tbl.push_back(mv(idle(), 1,0,0,1,2,0,0,1,'h108,1));
    tbl.push_back(mv(idle(), 1,0,0,1,1,0,0,1,'h10c,0));
    tbl.push_back(mv(idle(), 1,0,0,1,0,0,0,0,0,0));

    foreach (tbl[k]) begin
      cyc(tbl[k].i);
      chk($sformatf("t%0d_qrdy", k), 32'(if_query_ready), 32'(tbl[k].qrdy));
      chk($sformatf("t%0d_rv", k), 32'(if_resp_valid), 32'(tbl[k].rv));
      chk($sformatf("t%0d_rt", k), 32'(if_resp_taken), 32'(tbl[k].rt));
      chk($sformatf("t%0d_urdy", k), 32'(rob_upd_ready), 32'(tbl[k].urdy));
      chk($sformatf("t%0d_cnt", k), 32'(upd_count), 32'(tbl[k].cnt));
      chk($sformatf("t%0d_qen", k), 32'(bp_query_en), 32'(tbl[k].qen));
      chk($sformatf("t%0d_qpc", k), bp_query_pc, tbl[k].qpc);
      chk($sformatf("t%0d_uen", k), 32'(bp_update_en), 32'(tbl[k].uen));
      chk($sformatf("t%0d_upc", k), bp_update_pc, tbl[k].upc);
      chk($sformatf("t%0d_ures", k), 32'(bp_update_res), 32'(tbl[k].ures));
    end

    // Starvation: one buffered update against a continuous query stream
    cyc(mi(1,1,0,0,0,1,'h200,1,0,0));
    nq = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(mi(1,1,0,1,32'h40 + 32'(k),0,0,0,0,0));
      if (bp_update_en) begin
        seen = 1;
        chk("starve_upc", bp_update_pc, 32'h200);
        chk("starve_qrdy", 32'(if_query_ready), 0);
      end else if (bp_query_en) begin
        nq++;
      end
    end
    chk("starve_seen", 32'(seen), 1);
    chk("starve_nq", 32'(nq), 8);
    cyc(mi(1,1,0,1,'h80,0,0,0,0,0));
    chk("starve_after", 32'(bp_query_en), 1);

    // Pause holds the pending response until the next active cycle
    cyc(mi(1,1,0,1,'h50,0,0,0,0,0));
    for (int k = 0; k < 3; k++) begin
      cyc(mi(1,0,0,1,'h54,1,'h400,0,1,1));
      chk("pause_rv", 32'(if_resp_valid), 0);
      chk("pause_qen", 32'(bp_query_en), 0);
    end
    cyc(mi(1,1,0,0,0,0,0,0,1,1));
    chk("resume_rv", 32'(if_resp_valid), 1);
    chk("resume_rt", 32'(if_resp_taken), 1);
    cyc(mi(1,1,0,0,0,0,0,0,1,1));
    chk("resume_once", 32'(if_resp_valid), 0);

    // Flush in the response cycle drops it; a later query is unaffected
    cyc(mi(1,1,0,1,'h54,0,0,0,0,0));
    cyc(mi(1,1,1,1,'h58,0,0,0,1,1));
    chk("flush_rv", 32'(if_resp_valid), 0);
    chk("flush_qen", 32'(bp_query_en), 0);
    cyc(mi(1,1,0,0,0,0,0,0,1,1));
    chk("flush_drop", 32'(if_resp_valid), 0);
    cyc(mi(1,1,0,1,'h5c,0,0,0,0,0));
    cyc(mi(1,1,0,0,0,0,0,0,1,0));
    chk("post_flush_rv", 32'(if_resp_valid), 1);
    chk("post_flush_rt", 32'(if_resp_taken), 0);

    // Push and pop together at count 2
    cyc(mi(1,1,0,1,'h60,1,'h300,1,0,0));
    cyc(mi(1,1,0,1,'h64,1,'h304,0,0,0));
    cyc(mi(1,1,0,0,0,1,'h308,1,0,0));
    chk("pp_cnt", 32'(upd_count), 2);
    chk("pp_upc", bp_update_pc, 32'h300);
    cyc(idle());
    chk("pp_cnt_hold", 32'(upd_count), 2);
    chk("pp_upc2", bp_update_pc, 32'h304);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      v = mi(($urandom_range(63) != 0), ($urandom_range(99) < 85),
             ($urandom_range(9) == 0), ($urandom_range(99) < 60),
             $urandom, ($urandom_range(1) == 1), $urandom,
             ($urandom_range(1) == 1), ($urandom_range(3) != 0),
             ($urandom_range(1) == 1));
      cyc(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
